simeck_job_sequencer: RTL and testbench
=======================================

Name: simeck_job_sequencer

Overview:
Job-level controller for the Simeck round datapath (key/data word loaders, LFSR constant generator, round core).
- Accepts one encrypt/decrypt job at a time over a valid/ready input channel.
- Serially loads the 4 key words and 2 data words, then enables ROUNDS round iterations.
- Captures the datapath result and returns it over a valid/ready output channel.

Parameters:
DATAW, 16, word width; block = 2*DATAW bits, key = 4*DATAW bits
ROUNDS, 32, number of round iterations per job (must be >= 1)
CNTW, 6, counter width; 2**CNTW must be > ROUNDS

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
in_valid  in  1  job request valid
in_ready  out  1  sequencer can accept a job
in_mode  in  1  0 = encrypt, 1 = decrypt
in_data  in  2*DATAW  plaintext/ciphertext block
in_key  in  4*DATAW  key; word k = in_key[(k+1)*DATAW-1 : k*DATAW]
abort  in  1  synchronous job cancel
key_word  out  DATAW  key word to datapath loader
data_word  out  DATAW  data word to datapath loader
kload  out  1  key_word valid this cycle
dload  out  1  data_word valid this cycle
lfsr_init  out  1  hold round-constant LFSR at seed
round_en  out  1  advance one round this cycle
round_idx  out  CNTW  current round number
dp_mode  out  1  direction for datapath, stable for the whole job
dp_result  in  2*DATAW  datapath output block
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  2*DATAW  captured result
busy  out  1  state != IDLE
jobs_done  out  8  completed-job count, wraps 255 -> 0

Behaviour:
- States: IDLE, LOADK, LOADD, RUN, CAPT, WAIT.
- Datapath controls are decoded only from state, counter and job registers. No combinational path from any input to any output.
- Reset (async, any state, mid-job included): state = IDLE; counter = 0; job registers = 0; out_valid = 0; out_data = 0; jobs_done = 0; dp_mode = 0.
- Reset values of decoded outputs: kload = dload = round_en = 0; key_word = data_word = 0; round_idx = 0; in_ready = 1; busy = 0; lfsr_init = 1.
- in_ready = 1 only in IDLE.
- IDLE: on an edge with in_valid & in_ready, capture in_data, in_key and in_mode; go to LOADK with counter = 0.
- LOADK, 4 cycles: kload = 1, key_word = key word[counter] for counter = 0..3, lfsr_init = 1. Go to LOADD after counter = 3.
- LOADD, 2 cycles: dload = 1, data_word = data low word, then data high word. lfsr_init = 1. Go to RUN with counter = 0.
- RUN, ROUNDS cycles: round_en = 1, lfsr_init = 0, round_idx = counter (0..ROUNDS-1). Go to CAPT after counter = ROUNDS-1.
- CAPT, 1 cycle: out_data <= dp_result; out_valid <= 1; go to WAIT.
- WAIT: out_data is held stable. On out_ready: out_valid <= 0; jobs_done += 1; go to IDLE.
- Latency: out_valid is first high in the cycle after edge ROUNDS+7, counted from the accepting edge (39 for the defaults).
- Outside their states, key_word and data_word = 0. round_idx = 0 outside RUN.
- dp_mode is held from the accept edge until the return to IDLE.
- abort, in any non-IDLE state: next state = IDLE, counter = 0, out_valid <= 0, jobs_done unchanged.
  - abort wins over a simultaneous out_ready in WAIT; that result is dropped and not counted.
  - abort in IDLE is ignored, and a job presented in the same cycle is accepted.
- in_valid while busy: ignored; the requester must hold it.
- Back-to-back jobs: at least one IDLE cycle between consecutive jobs.
- Counter arithmetic is modulo 2**CNTW. The state transitions above keep the counter below ROUNDS.

Test Plan:
- Reset release, then in_valid with key=0x1918_1110_0908_0100, data=0x6565_6877, mode=0, DATAW=16 -> key_word 0x0100, 0x0908, 0x1110, 0x1918 with kload; data_word 0x6877, 0x6565 with dload; 32 round_en cycles with round_idx 0..31; out_valid first high in the cycle after edge 39; out_data equals dp_result sampled in CAPT.
- out_ready held low for 10 cycles in WAIT -> out_valid and out_data stable, in_ready = 0; raising out_ready -> IDLE next cycle, jobs_done = 1.
- abort asserted in RUN at round_idx = 12 -> IDLE next cycle, round_en = 0, out_valid never rises, jobs_done unchanged; a new job is then accepted normally.
- abort and out_ready high in the same WAIT cycle -> out_valid drops, jobs_done not incremented.
- rst_n pulsed low asynchronously mid-LOADD -> all outputs at reset values immediately; in_ready = 1 after release.
- 256 complete jobs with mode alternating -> dp_mode matches each job for its whole duration; jobs_done wraps to 0.

Source files
------------

// File: rtl/simeck_job_sequencer.sv
// Job-level sequencer for the Simeck round datapath: loads key/data words serially,
// runs ROUNDS round iterations, then returns the captured result over valid/ready.
module simeck_job_sequencer #(
  parameter int unsigned DATAW  = 16,
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned CNTW   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [2*DATAW-1:0]  in_data,
  input  logic [4*DATAW-1:0]  in_key,
  input  logic                abort,
  output logic [DATAW-1:0]    key_word,
  output logic [DATAW-1:0]    data_word,
  output logic                kload,
  output logic                dload,
  output logic                lfsr_init,
  output logic                round_en,
  output logic [CNTW-1:0]     round_idx,
  output logic                dp_mode,
  input  logic [2*DATAW-1:0]  dp_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATAW-1:0]  out_data,
  output logic                busy,
  output logic [7:0]          jobs_done
);

  typedef enum logic [2:0] {StIdle, StLoadK, StLoadD, StRun, StCapt, StWait} state_e;

  localparam logic [CNTW-1:0] LastRound = CNTW'(ROUNDS - 1);
  localparam logic [CNTW-1:0] LastKey   = CNTW'(3);
  localparam logic [CNTW-1:0] LastData  = CNTW'(1);

  state_e               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [2*DATAW-1:0]   data_q, data_d;
  logic [4*DATAW-1:0]   key_q, key_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*DATAW-1:0]   out_data_q, out_data_d;
  logic [7:0]           jobs_q, jobs_d;
  logic [DATAW-1:0]     key_w [4];

  for (genvar k = 0; k < 4; k++) begin : g_key_w
    assign key_w[k] = key_q[k*DATAW +: DATAW];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    data_d      = data_q;
    key_d       = key_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    jobs_d      = jobs_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mode_d  = in_mode;
          data_d  = in_data;
          key_d   = in_key;
          cnt_d   = '0;
          state_d = StLoadK;
        end
      end
      StLoadK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastKey) begin
          cnt_d   = '0;
          state_d = StLoadD;
        end
      end
      StLoadD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastData) begin
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastRound) begin
          cnt_d   = '0;
          state_d = StCapt;
        end
      end
      StCapt: begin
        out_data_d  = dp_result;
        out_valid_d = 1'b1;
        state_d     = StWait;
      end
      StWait: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          jobs_d      = jobs_q + 8'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort overrides everything, including a completing handshake in WAIT.
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      jobs_d      = jobs_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      data_q      <= '0;
      key_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      jobs_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      key_q       <= key_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      jobs_q      <= jobs_d;
    end
  end

  always_comb begin
    kload     = 1'b0;
    dload     = 1'b0;
    round_en  = 1'b0;
    key_word  = '0;
    data_word = '0;
    round_idx = '0;
    unique case (state_q)
      StLoadK: begin
        kload    = 1'b1;
        key_word = key_w[cnt_q[1:0]];
      end
      StLoadD: begin
        dload     = 1'b1;
        data_word = cnt_q[0] ? data_q[2*DATAW-1:DATAW] : data_q[DATAW-1:0];
      end
      StRun: begin
        round_en  = 1'b1;
        round_idx = cnt_q;
      end
      default: ;
    endcase
  end

  assign lfsr_init = (state_q != StRun);
  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign dp_mode   = mode_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign jobs_done = jobs_q;

endmodule

// File: tb/tb_simeck_job_sequencer.sv
// Scoreboard bench for simeck_job_sequencer: walks every job cycle by cycle against
// expected control vectors and checks captured results popped from a queue.
module tb_simeck_job_sequencer;
  localparam int DW  = 16;
  localparam int RND = 32;
  localparam int CW  = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0, in_ready, in_mode = 1'b0;
  logic [2*DW-1:0] in_data = '0;
  logic [4*DW-1:0] in_key = '0;
  logic            abort = 1'b0;
  logic [DW-1:0]   key_word, data_word;
  logic            kload, dload, lfsr_init, round_en, dp_mode;
  logic [CW-1:0]   round_idx;
  logic [2*DW-1:0] dp_result, out_data;
  logic            out_valid, out_ready = 1'b0, busy;
  logic [7:0]      jobs_done;

  int unsigned     tick = 0;
  int              n_cmp = 0;
  int              n_err = 0;
  logic [7:0]      exp_jobs = 8'd0;
  logic [2*DW-1:0] sb_q[$];
  logic [2*DW-1:0] held;

  simeck_job_sequencer #(.DATAW(DW), .ROUNDS(RND), .CNTW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_key(in_key), .abort(abort), .key_word(key_word),
    .data_word(data_word), .kload(kload), .dload(dload), .lfsr_init(lfsr_init),
    .round_en(round_en), .round_idx(round_idx), .dp_mode(dp_mode), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  // Datapath stand-in: a value that changes every cycle, so capturing on the wrong edge shows.
  function automatic logic [2*DW-1:0] dp_fn(input int unsigned t);
    return {DW'(t * 7 + 1), DW'(t ^ 32'h5a5a)};
  endfunction
  assign dp_result = dp_fn(tick);

  // {kload, key_word, dload, data_word, round_en, round_idx, lfsr_init, dp_mode, busy, in_ready}
  function automatic logic [44:0] obs();
    return {kload, key_word, dload, data_word, round_en, round_idx, lfsr_init, dp_mode, busy,
            in_ready};
  endfunction

  task automatic send_job(input logic [4*DW-1:0] k, input logic [2*DW-1:0] d, input logic m);
    @(negedge clk);
    in_valid = 1'b1; in_key = k; in_data = d; in_mode = m;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL accept_ready: got %b want 1", in_ready);
    end
    sb_q.push_back(dp_fn(tick + RND + 7));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic walk_load(input logic [4*DW-1:0] k, input logic [2*DW-1:0] d, input logic m,
                           input int nd);
    logic [44:0] e;
    for (int i = 0; i < 4; i++) begin
      e = {1'b1, k[i*DW +: DW], 1'b0, 16'h0, 1'b0, 6'd0, 1'b1, m, 1'b1, 1'b0};
      n_cmp++;
      if (obs() !== e) begin
        n_err++; $display("FAIL loadk[%0d]: got %h want %h", i, obs(), e);
      end
      @(negedge clk);
    end
    for (int i = 0; i < nd; i++) begin
      e = {1'b0, 16'h0, 1'b1, d[i*DW +: DW], 1'b0, 6'd0, 1'b1, m, 1'b1, 1'b0};
      n_cmp++;
      if (obs() !== e) begin
        n_err++; $display("FAIL loadd[%0d]: got %h want %h", i, obs(), e);
      end
      @(negedge clk);
    end
  endtask

  task automatic walk_run(input logic m, input int n);
    logic [44:0] e;
    for (int r = 0; r < n; r++) begin
      e = {1'b0, 16'h0, 1'b0, 16'h0, 1'b1, CW'(r), 1'b0, m, 1'b1, 1'b0};
      n_cmp++;
      if ((obs() !== e) || (out_valid !== 1'b0)) begin
        n_err++; $display("FAIL run[%0d]: got %h/%b want %h/0", r, obs(), out_valid, e);
      end
      @(negedge clk);
    end
  endtask

  // Enters on the CAPT cycle, leaves on the first WAIT cycle with the result checked.
  task automatic finish_capt(input logic m);
    logic [44:0]     e;
    logic [2*DW-1:0] want;
    e = {1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b1, m, 1'b1, 1'b0};
    n_cmp++;
    if ((obs() !== e) || (out_valid !== 1'b0)) begin
      n_err++; $display("FAIL capt: got %h/%b want %h/0", obs(), out_valid, e);
    end
    @(negedge clk);
    want = sb_q.pop_front();
    n_cmp++;
    if ((out_valid !== 1'b1) || (out_data !== want)) begin
      n_err++; $display("FAIL result: got %b/%h want 1/%h", out_valid, out_data, want);
    end
    held = want;
  endtask

  task automatic complete(input logic m, input int hold);
    logic [44:0] e;
    e = {1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b1, m, 1'b1, 1'b0};
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ((out_valid !== 1'b1) || (out_data !== held) || (obs() !== e)) begin
        n_err++;
        $display("FAIL wait_hold[%0d]: got %b/%h/%h want 1/%h/%h", i, out_valid, out_data,
                 obs(), held, e);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_jobs = exp_jobs + 8'd1;
    n_cmp++;
    if ((busy !== 1'b0) || (in_ready !== 1'b1) || (out_valid !== 1'b0) ||
        (jobs_done !== exp_jobs)) begin
      n_err++;
      $display("FAIL release: got busy=%b rdy=%b ov=%b jobs=%0d want 0/1/0/%0d", busy,
               in_ready, out_valid, jobs_done, exp_jobs);
    end
  endtask

  task automatic full_job(input logic [4*DW-1:0] k, input logic [2*DW-1:0] d, input logic m,
                          input int hold);
    send_job(k, d, m);
    walk_load(k, d, m, 2);
    walk_run(m, RND);
    finish_capt(m);
    complete(m, hold);
  endtask

  task automatic test_reset();
    logic [44:0] e;
    e = {1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ((obs() !== e) || (out_valid !== 1'b0) || (out_data !== '0) || (jobs_done !== 8'd0)) begin
      n_err++; $display("FAIL reset_vals: got %h/%b/%h/%0d want %h/0/0/0", obs(), out_valid,
                        out_data, jobs_done, e);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_jobs = 8'd0;
    sb_q.delete();
    @(negedge clk);
    n_cmp++;
    if (obs() !== e) begin
      n_err++; $display("FAIL post_reset: got %h want %h", obs(), e);
    end
  endtask

  task automatic test_basic();
    full_job(64'h1918_1110_0908_0100, 32'h6565_6877, 1'b0, 10);
  endtask

  task automatic test_abort_run();
    logic [4*DW-1:0] k;
    logic [2*DW-1:0] d;
    logic [2*DW-1:0] drop;
    logic            rose;
    k = {$urandom, $urandom};
    d = $urandom;
    send_job(k, d, 1'b1);
    walk_load(k, d, 1'b1, 2);
    walk_run(1'b1, 12);
    n_cmp++;
    if ((round_idx !== 6'd12) || (round_en !== 1'b1)) begin
      n_err++; $display("FAIL abort_at: got idx=%0d en=%b want 12/1", round_idx, round_en);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drop = sb_q.pop_front();
    n_cmp++;
    if ((busy !== 1'b0) || (round_en !== 1'b0) || (in_ready !== 1'b1) ||
        (jobs_done !== exp_jobs) || (out_valid !== 1'b0)) begin
      n_err++; $display("FAIL abort_run: got busy=%b en=%b rdy=%b jobs=%0d ov=%b want 0/0/1/%0d/0",
                        busy, round_en, in_ready, jobs_done, out_valid, exp_jobs);
    end
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) rose = 1'b1;
    end
    n_cmp++;
    if (rose !== 1'b0) begin
      n_err++; $display("FAIL abort_no_result: got rose=%b want 0 (dropped %h)", rose, drop);
    end
    full_job(k, d, 1'b0, 0);
  endtask

  task automatic test_abort_wait();
    logic [4*DW-1:0] k;
    logic [2*DW-1:0] d;
    k = {$urandom, $urandom};
    d = $urandom;
    send_job(k, d, 1'b0);
    walk_load(k, d, 1'b0, 2);
    walk_run(1'b0, RND);
    finish_capt(1'b0);
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if ((out_valid !== 1'b0) || (jobs_done !== exp_jobs) || (busy !== 1'b0)) begin
      n_err++; $display("FAIL abort_wait: got ov=%b jobs=%0d busy=%b want 0/%0d/0", out_valid,
                        jobs_done, busy, exp_jobs);
    end
  endtask

  task automatic test_async_reset();
    logic [4*DW-1:0] k;
    logic [2*DW-1:0] d;
    logic [44:0]     e;
    k = {$urandom, $urandom};
    d = $urandom;
    e = {1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    send_job(k, d, 1'b1);
    walk_load(k, d, 1'b1, 1);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ((obs() !== e) || (out_valid !== 1'b0) || (out_data !== '0) || (jobs_done !== 8'd0)) begin
      n_err++; $display("FAIL async_reset: got %h/%b/%h/%0d want %h/0/0/0", obs(), out_valid,
                        out_data, jobs_done, e);
    end
    sb_q.delete();
    exp_jobs = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ((in_ready !== 1'b1) || (busy !== 1'b0)) begin
      n_err++; $display("FAIL after_release: got rdy=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 256; j++) begin
      full_job({$urandom, $urandom}, $urandom, 1'(j & 1), 0);
    end
    n_cmp++;
    if (jobs_done !== 8'd0) begin
      n_err++; $display("FAIL jobs_wrap: got %0d want 0", jobs_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort_run();
    test_abort_wait();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
